// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus definitions: response acceptance modes for sink masters.
package pzcorebus_pkg;
    typedef enum logic [1:0] {
        PZCOREBUS_RESPONSE_ACCEPT_NEVER,
        PZCOREBUS_RESPONSE_ACCEPT_ALWAYS,
        PZCOREBUS_RESPONSE_ACCEPT_THROTTLE
    } pzcorebus_response_accept_mode;
endpackage

// File: rtl/pzcorebus_if.sv
// pzcorebus response channel: slave presents beats, master accepts them.
interface pzcorebus_if;
    logic mresp_accept;
    logic sresp_valid;
    logic slast;
    logic serror;

    modport response_master (
        output mresp_accept,
        input  sresp_valid,
        input  slast,
        input  serror
    );

    modport response_slave (
        input  mresp_accept,
        output sresp_valid,
        output slast,
        output serror
    );
endinterface

// File: rtl/pzcorebus_response_sink_counter.sv
// Saturating statistics counter with synchronous reset and clear.
module pzcorebus_response_sink_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // A clear wins over an increment arriving in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pzcorebus_response_sink_master.sv
// Response sink: accepts pzcorebus response beats per a fixed mode and keeps beat/response/error statistics.
module pzcorebus_response_sink_master
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_response_accept_mode ACCEPT_MODE   = PZCOREBUS_RESPONSE_ACCEPT_ALWAYS,
    parameter int unsigned                   ACCEPT_CYCLES = 1,
    parameter int unsigned                   STALL_CYCLES  = 1,
    parameter int unsigned                   COUNT_WIDTH   = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic                       i_clear,
    pzcorebus_if.response_master       master_if,
    output logic [COUNT_WIDTH-1:0]     o_beat_count,
    output logic [COUNT_WIDTH-1:0]     o_response_count,
    output logic [COUNT_WIDTH-1:0]     o_error_count,
    output logic                       o_in_burst
);
    localparam int unsigned PERIOD  = ACCEPT_CYCLES + STALL_CYCLES;
    localparam int unsigned PHASE_W = $clog2(PERIOD + 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(PERIOD - 1);
    localparam logic [PHASE_W-1:0] ACCEPT_LIMIT = PHASE_W'(ACCEPT_CYCLES);

    typedef enum logic {
        BURST_IDLE,
        BURST_ACTIVE
    } burst_state_t;

    logic [PHASE_W-1:0] r_phase;
    burst_state_t       r_state;
    logic               w_accept;
    logic               w_beat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= '0;
        end else if (i_enable) begin
            r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + PHASE_W'(1);
        end
    end

    // Acceptance never looks at sresp_valid; i_rst masks it during reset.
    always_comb begin
        w_accept = 1'b0;
        if (!i_rst && i_enable) begin
            case (ACCEPT_MODE)
                PZCOREBUS_RESPONSE_ACCEPT_ALWAYS:   w_accept = 1'b1;
                PZCOREBUS_RESPONSE_ACCEPT_THROTTLE: w_accept = (r_phase < ACCEPT_LIMIT);
                default:                            w_accept = 1'b0;
            endcase
        end
    end

    assign master_if.mresp_accept = w_accept;
    assign w_beat                 = master_if.sresp_valid && w_accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= BURST_IDLE;
        end else if (w_beat) begin
            case (r_state)
                BURST_IDLE:   if (!master_if.slast) r_state <= BURST_ACTIVE;
                BURST_ACTIVE: if (master_if.slast)  r_state <= BURST_IDLE;
                default:      r_state <= BURST_IDLE;
            endcase
        end
    end

    assign o_in_burst = (r_state == BURST_ACTIVE);

    pzcorebus_response_sink_counter #(.WIDTH(COUNT_WIDTH)) u_beat_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_inc   (w_beat),
        .o_count (o_beat_count)
    );

    pzcorebus_response_sink_counter #(.WIDTH(COUNT_WIDTH)) u_response_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_inc   (w_beat && master_if.slast),
        .o_count (o_response_count)
    );

    pzcorebus_response_sink_counter #(.WIDTH(COUNT_WIDTH)) u_error_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_inc   (w_beat && master_if.serror),
        .o_count (o_error_count)
    );
endmodule

// File: tb/tb_pzcorebus_response_sink_master.sv
// Directed bench for pzcorebus_response_sink_master across ALWAYS, THROTTLE, narrow-counter and NEVER builds.
module tb_pzcorebus_response_sink_master;
    import pzcorebus_pkg::*;

    logic clk;
    logic rst;
    logic en;
    logic clr;

    pzcorebus_if if_a ();
    pzcorebus_if if_b ();
    pzcorebus_if if_c ();
    pzcorebus_if if_d ();

    logic [31:0] beat_a, resp_a, err_a, beat_b, resp_b, err_b, beat_d, resp_d, err_d;
    logic [3:0]  beat_c, resp_c, err_c;
    logic        inb_a, inb_b, inb_c, inb_d;

    int unsigned n_pass;
    int unsigned n_total;

    pzcorebus_response_sink_master #(
        .ACCEPT_MODE(PZCOREBUS_RESPONSE_ACCEPT_ALWAYS), .COUNT_WIDTH(32)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clear(clr), .master_if(if_a),
        .o_beat_count(beat_a), .o_response_count(resp_a), .o_error_count(err_a), .o_in_burst(inb_a)
    );

    pzcorebus_response_sink_master #(
        .ACCEPT_MODE(PZCOREBUS_RESPONSE_ACCEPT_THROTTLE), .ACCEPT_CYCLES(2), .STALL_CYCLES(1), .COUNT_WIDTH(32)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clear(clr), .master_if(if_b),
        .o_beat_count(beat_b), .o_response_count(resp_b), .o_error_count(err_b), .o_in_burst(inb_b)
    );

    pzcorebus_response_sink_master #(
        .ACCEPT_MODE(PZCOREBUS_RESPONSE_ACCEPT_ALWAYS), .COUNT_WIDTH(4)
    ) dut_c (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clear(clr), .master_if(if_c),
        .o_beat_count(beat_c), .o_response_count(resp_c), .o_error_count(err_c), .o_in_burst(inb_c)
    );

    pzcorebus_response_sink_master #(
        .ACCEPT_MODE(PZCOREBUS_RESPONSE_ACCEPT_NEVER), .COUNT_WIDTH(32)
    ) dut_d (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clear(clr), .master_if(if_d),
        .o_beat_count(beat_d), .o_response_count(resp_d), .o_error_count(err_d), .o_in_burst(inb_d)
    );

    typedef struct {
        logic        en;
        logic        valid;
        logic        last;
        logic        err;
        logic        clr;
        logic        exp_acc;
        int unsigned exp_beat;
        int unsigned exp_resp;
        int unsigned exp_err;
        logic        exp_inb;
    } vec_t;

    vec_t vecs [15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_a.sresp_valid = 1'b0; if_a.slast = 1'b0; if_a.serror = 1'b0;
        if_b.sresp_valid = 1'b0; if_b.slast = 1'b0; if_b.serror = 1'b0;
        if_c.sresp_valid = 1'b0; if_c.slast = 1'b0; if_c.serror = 1'b0;
        if_d.sresp_valid = 1'b0; if_d.slast = 1'b0; if_d.serror = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        en  = 1'b1;
        clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] acc_seq;
        logic       never_acc;
        n_pass  = 0;
        n_total = 0;

        // beat: en, valid, last, err, clr | accept, beat, resp, err, in_burst
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 2, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 3, 0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1, 1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1, 1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1, 1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1, 1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1, 1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6, 2, 1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0};

        idle_all();
        rst = 1'b1;
        en  = 1'b1;
        clr = 1'b0;
        tick();
        tick();

        // Reset state, still inside reset.
        check("rst_acc_a", if_a.mresp_accept, 0);
        check("rst_acc_b", if_b.mresp_accept, 0);
        check("rst_acc_c", if_c.mresp_accept, 0);
        check("rst_beat_a", beat_a, 0);
        check("rst_resp_b", resp_b, 0);
        check("rst_err_c", err_c, 0);
        check("rst_inb_a", inb_a, 0);

        // Throttle 2/1 with valid held from reset release.
        rst = 1'b0;
        if_b.sresp_valid = 1'b1;
        if_b.slast = 1'b1;
        acc_seq = 6'b011011;
        for (int k = 0; k < 6; k++) begin
            #4;
            check($sformatf("thr_acc%0d", k), if_b.mresp_accept, acc_seq[k]);
            tick();
        end
        check("thr_beat", beat_b, 4);
        check("thr_resp", resp_b, 4);
        if_b.sresp_valid = 1'b0;

        // Table-driven sequence on the ALWAYS build.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            en  = vecs[i].en;
            clr = vecs[i].clr;
            if_a.sresp_valid = vecs[i].valid;
            if_a.slast       = vecs[i].last;
            if_a.serror      = vecs[i].err;
            #4;
            check($sformatf("vec%0d_acc", i), if_a.mresp_accept, vecs[i].exp_acc);
            tick();
            check($sformatf("vec%0d_beat", i), beat_a, vecs[i].exp_beat);
            check($sformatf("vec%0d_resp", i), resp_a, vecs[i].exp_resp);
            check($sformatf("vec%0d_err", i), err_a, vecs[i].exp_err);
            check($sformatf("vec%0d_inb", i), inb_a, vecs[i].exp_inb);
        end
        idle_all();
        clr = 1'b0;
        en  = 1'b1;

        // 4-bit counters: saturation, then clear with a concurrent beat.
        do_reset();
        if_c.sresp_valid = 1'b1;
        if_c.slast = 1'b1;
        if_c.serror = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        check("sat_resp14", resp_c, 14);
        for (int k = 0; k < 3; k++) tick();
        check("sat_resp17", resp_c, 15);
        check("sat_beat17", beat_c, 15);
        check("sat_err17", err_c, 15);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        if_c.sresp_valid = 1'b0;
        check("clr_beat", beat_c, 0);
        check("clr_resp", resp_c, 0);
        check("clr_err", err_c, 0);

        // NEVER mode ignores 100 cycles of valid.
        do_reset();
        if_d.sresp_valid = 1'b1;
        if_d.slast = 1'b1;
        if_d.serror = 1'b1;
        never_acc = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #4;
            never_acc = never_acc | if_d.mresp_accept;
            tick();
        end
        check("never_acc", never_acc, 0);
        check("never_beat", beat_d, 0);
        check("never_resp", resp_d, 0);
        check("never_err", err_d, 0);
        if_d.sresp_valid = 1'b0;

        // Reset pulsed after beat 2 of a 4-beat burst.
        do_reset();
        if_a.sresp_valid = 1'b1;
        if_a.slast = 1'b0;
        tick();
        tick();
        check("mid_beat2", beat_a, 2);
        check("mid_inb2", inb_a, 1);
        rst = 1'b1;
        #4;
        check("mid_rst_acc", if_a.mresp_accept, 0);
        tick();
        check("mid_rst_beat", beat_a, 0);
        check("mid_rst_inb", inb_a, 0);
        rst = 1'b0;
        if_a.slast = 1'b1;
        tick();
        if_a.sresp_valid = 1'b0;
        check("post_rst_resp", resp_a, 1);
        check("post_rst_beat", beat_a, 1);
        check("post_rst_inb", inb_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
